// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: received byte, holding-register
// handshake and the per-frame status pulses. The receiver drives it through
// the master modport; the loader/MMIO logic reads it through the slave modport.
interface uart_rx_if;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       rx_ack;
    logic       ferr;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output rdata,
        output rx_valid,
        input  rx_ack,
        output ferr,
        output overrun,
        output rx_busy
    );

    modport slave (
        input  rdata,
        input  rx_valid,
        output rx_ack,
        input  ferr,
        input  overrun,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The asynchronous rxd pin passes through a two-flop
// synchroniser. A start bit is qualified at half a bit period, and each data
// bit and the stop bit are sampled at mid-bit. Good bytes land in a one-entry
// holding register that is released by rx_ack. CLK_PER_HALF_BIT (H) is shared
// with the transmitter, so both ends agree on the bit period (2H clocks).
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 30
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     rxd,
    uart_rx_if.master rx
);

    // Terminal counts. 2H-1 still fits in 16 bits at H = 2^15.
    localparam logic [15:0] HALF_LAST = 16'(CLK_PER_HALF_BIT - 1);
    localparam logic [15:0] FULL_LAST = 16'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        s1_r;
    logic        s2_r;
    logic [15:0] cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shreg_r;

    logic [7:0]  rdata_r;
    logic        valid_r;
    logic        ferr_r;
    logic        overrun_r;
    logic        busy_r;

    // Strobes decoded from the current state for the datapath.
    logic        cnt_clr_s;
    logic        cnt_inc_s;
    logic        bit_clr_s;
    logic        shift_s;
    logic        good_s;
    logic        bad_s;

    // Two-flop synchroniser. Both flops reset to the idle-high line level, so
    // only a genuine low seen after reset can open a frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s1_r <= rxd;
            s2_r <= s1_r;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath strobes. Each bit-timed state either advances
    // the cycle counter or, at its terminal count, acts on the sampled s2.
    always_comb begin
        state_next_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        bit_clr_s    = 1'b0;
        shift_s      = 1'b0;
        good_s       = 1'b0;
        bad_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!s2_r) begin
                    state_next_s = START;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (s2_r) begin
                        // Line already back high at mid-start: treat it as a glitch.
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DATA;
                        bit_clr_s    = 1'b1;
                    end
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_clr_s = 1'b1;
                    shift_s   = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (s2_r) begin
                        good_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        // Framing error. A line held low (break) must go high
                        // before another start edge is accepted.
                        bad_s        = 1'b1;
                        state_next_s = WAIT_HIGH;
                    end
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (s2_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_HIGH;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // Cycle counter, bit index and LSB-first shift register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
        end else begin
            if (cnt_clr_s) begin
                cnt_r <= 16'd0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (bit_clr_s) begin
                bit_idx_r <= 3'd0;
            end else if (shift_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end

            if (shift_s) begin
                shreg_r <= {s2_r, shreg_r[7:1]};
            end else begin
                shreg_r <= shreg_r;
            end
        end
    end

    // Holding register and status pulses. A completing byte always wins over
    // rx_ack, so a coincident ack keeps rx_valid high with the new byte and
    // counts as a consumed predecessor rather than an overrun.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_r   <= 8'h00;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (good_s) begin
                rdata_r   <= shreg_r;
                valid_r   <= 1'b1;
                overrun_r <= valid_r & ~rx.rx_ack;
            end else if (rx.rx_ack && valid_r) begin
                rdata_r   <= rdata_r;
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end else begin
                rdata_r   <= rdata_r;
                valid_r   <= valid_r;
                overrun_r <= 1'b0;
            end
            ferr_r <= bad_s;
            busy_r <= (state_next_s != IDLE);
        end
    end

    assign rx.rdata    = rdata_r;
    assign rx.rx_valid = valid_r;
    assign rx.ferr     = ferr_r;
    assign rx.overrun  = overrun_r;
    assign rx.rx_busy  = busy_r;

endmodule
